// File: rtl/jtpopeye_obj_draw.sv
// jtpopeye_obj_draw: fetches 2bpp object rows from ROM and paints them into a double-banked line buffer.
// Define JTPOPEYE_OBJ_PRIO_EN to give the first-drawn object priority (2 clk per pixel).
module jtpopeye_obj_draw #(
    parameter int ROMW = 13,
    parameter int BUFW = 5
) (
    input  logic            rst_n,
    input  logic            clk,
    input  logic            pxl_cen,
    input  logic            hs,
    input  logic [7:0]      H,
    input  logic            dj_stb,
    input  logic [17:0]     DJ,
    input  logic [7:0]      obj_x,
    output logic [ROMW-1:0] rom_addr,
    output logic            rom_cs,
    input  logic [31:0]     rom_data,
    input  logic            rom_ok,
    output logic            busy,
    output logic            ovf,
    output logic [BUFW-1:0] obj_pix
);
`ifdef JTPOPEYE_OBJ_PRIO_EN
    localparam int CW = 5;
`else
    localparam int CW = 4;
`endif
    typedef enum logic [1:0] {IDLE, FETCH, DRAW} state_t;
    state_t          state_q, state_d;
    logic [17:1]     dj_q, dj_d, skid_q, skid_d;
    logic [7:0]      x_q, x_d, skid_x_q, skid_x_d;
    logic            skid_v_q, skid_v_d, ovf_q, ovf_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     rom_q;
    logic            hs_l_q, bank_q, started_q;
    logic [BUFW-1:0] pix_q;
    logic [BUFW-1:0] mem [2][256];
    logic            hs_rise, acc, idle_e, done, wr, wr_ok;
    logic [3:0]      idx, sel;
    logic [1:0]      pix;
    logic [8:0]      xi;
    logic            unused_dj0;

    assign unused_dj0 = DJ[0];
    assign hs_rise = hs & ~hs_l_q;
    assign acc     = dj_stb && DJ[16:14] != 3'd0;
    assign idle_e  = hs_rise || state_q == IDLE;
    assign done    = state_q == DRAW && &cnt_q;
    assign idx     = cnt_q[CW-1 -: 4];
    assign sel     = dj_q[17] ? idx : ~idx;
    assign pix     = {rom_q[{1'b1, sel}], rom_q[{1'b0, sel}]};
    assign xi      = {1'b0, x_q} + {5'd0, idx};
    assign wr      = state_q == DRAW && !hs_rise && pix != 2'd0 && !xi[8] && wr_ok;

`ifdef JTPOPEYE_OBJ_PRIO_EN
    // even clk samples the destination, odd clk writes only over transparent pixels
    logic [1:0] dst_q;
    assign wr_ok = cnt_q[0] && dst_q == 2'd0;
`else
    assign wr_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        dj_d     = dj_q;
        x_d      = x_q;
        skid_d   = skid_q;
        skid_x_d = skid_x_q;
        skid_v_d = skid_v_q;
        ovf_d    = ovf_q;
        cnt_d    = state_q == DRAW ? cnt_q + 1'b1 : '0;
        if (hs_rise) begin
            state_d  = IDLE;
            skid_v_d = 1'b0;
            ovf_d    = 1'b0;
        end else if (state_q == FETCH && rom_ok) begin
            state_d = DRAW;
        end else if (done) begin
            state_d  = skid_v_q ? FETCH : IDLE;
            dj_d     = skid_v_q ? skid_q : dj_q;
            x_d      = skid_v_q ? skid_x_q : x_q;
            skid_v_d = 1'b0;
        end
        if (acc) begin
            if (idle_e || (done && !skid_v_q)) begin
                dj_d    = DJ[17:1];
                x_d     = obj_x;
                state_d = FETCH;
            end else if (!skid_v_q) begin
                skid_d   = DJ[17:1];
                skid_x_d = obj_x;
                skid_v_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_comb begin
        rom_cs   = state_q == FETCH;
        busy     = state_q != IDLE;
        rom_addr = ROMW'(dj_q[13:1]);
        ovf      = ovf_q;
        obj_pix  = pix_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dj_q      <= '0;
            x_q       <= '0;
            skid_q    <= '0;
            skid_x_q  <= '0;
            skid_v_q  <= 1'b0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            rom_q     <= '0;
            hs_l_q    <= 1'b0;
            bank_q    <= 1'b0;
            started_q <= 1'b0;
            pix_q     <= '0;
        end else begin
            dj_q     <= dj_d;
            x_q      <= x_d;
            skid_q   <= skid_d;
            skid_x_q <= skid_x_d;
            skid_v_q <= skid_v_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
            hs_l_q   <= hs;
            if (hs_rise) begin
                bank_q    <= ~bank_q;
                started_q <= 1'b1;
            end
            if (state_q == FETCH && rom_ok && !hs_rise) rom_q <= rom_data;
            if (pxl_cen) pix_q <= started_q ? mem[~bank_q][H] : '0;
        end
    end

    // draw bank = bank_q, read bank = ~bank_q; readout clears behind itself
    always_ff @(posedge clk) begin
        if (wr) mem[bank_q][xi[7:0]] <= BUFW'({dj_q[16:14], pix});
        if (pxl_cen) mem[~bank_q][H] <= '0;
`ifdef JTPOPEYE_OBJ_PRIO_EN
        if (state_q == DRAW && !cnt_q[0]) dst_q <= mem[bank_q][xi[7:0]][1:0];
`endif
    end
endmodule
